bit_serial_adder_ctrl: RTL and testbench
========================================

Name: bit_serial_adder_ctrl

Overview:
- Sequences the team's single-bit full-adder cell over WIDTH-bit operands, LSB first, one bit per clock, with a registered carry between bits.
- Front end accepts operands through a valid/ready handshake. Back end presents the result through a valid/ready handshake.
- Supports add-with-carry-in and two's-complement subtract.
- Trades WIDTH cycles of latency for a one-cell datapath. Intended as the arithmetic engine behind small Tiny Tapeout user designs.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  operand bundle present.
- start_ready  out  1  controller can accept an operand bundle.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1 = compute A-B, 0 = compute A+B+cin.
- res_valid  out  1  result bundle present.
- res_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; for subtract, 1 means no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, start_ready=1, res_valid=0, result=0, cout=0, overflow=0, bit counter=0, carry register=0. Reset overrides every other input, in any state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1, res_valid=0.
  - On an edge with start_valid=1, capture op_a into shift register A.
  - Capture op_b, or ~op_b when sub=1, into shift register B.
  - Carry register takes cin, or 1 when sub=1. Counter clears to 0. Go to RUN.
- RUN:
  - start_ready=0, res_valid=0.
  - Each edge feeds A[0], B[0] and the carry register to the full-adder cell.
  - The sum bit shifts into the result register MSB; the result register shifts right.
  - The cell carry-out loads the carry register. A and B shift right.
  - Counter increments.
  - On the edge where the counter equals WIDTH-1:
    - latch the cell carry-out into cout;
    - latch (carry-in of this bit) XOR (carry-out of this bit) into overflow;
    - go to DONE.
- DONE:
  - res_valid=1; result, cout and overflow held stable.
  - start_ready=0; start_valid is ignored.
  - On an edge with res_ready=1, go to IDLE; res_valid falls the next cycle. Result, cout and overflow keep their values until the next accept.
- Latency: res_valid rises exactly WIDTH+1 edges after the accepting edge (1 load edge + WIDTH RUN edges). Minimum issue interval is WIDTH+2 cycles; there is no back-to-back overlap.
- Operand inputs are sampled only on the accept edge. Changes during RUN or DONE have no effect.
- Counter width is clog2(WIDTH); it never wraps past WIDTH-1.
- Reset asserted mid-RUN aborts the operation with no partial result visible; the controller is ready the cycle after rst deasserts.
- Every output is a registered output; there are no combinational input-to-output paths.

Decomposition:
- Shared package bsa_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - function clog2 for the counter width;
  - localparam for the minimum WIDTH.
- Sub-module fa_bit_cell: purely combinational 1-bit full adder; inputs a, b, ci; outputs s, co.
  - The cell is instantiated once and is the only arithmetic in the block.
- The controller owns the FSM, the counter, the shift registers and the carry register.

Test Plan:
- WIDTH=8, A=0x5A, B=0x33, cin=0, sub=0 -> result=0x8D, cout=0, overflow=1. res_valid rises exactly 9 edges after accept.
- A=0xFF, B=0x01, cin=0, sub=0 -> result=0x00, cout=1, overflow=0. A=0x7F, B=0x00, cin=1 -> result=0x80, cout=0, overflow=1.
- Subtract: A=0x10, B=0x20, sub=1, cin=1 (must be ignored) -> result=0xF0, cout=0 (borrow), overflow=0. A=0x80, B=0x01, sub=1 -> result=0x7F, cout=1, overflow=1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while toggling start_valid and the operands.
  - Required: result, cout and overflow stable; start_ready=0.
  - Assert res_ready -> IDLE next cycle; a new accept is then possible.
- Reset mid-operation: assert rst after 3 RUN edges.
  - Next cycle: start_ready=1, res_valid=0, result=0, cout=0, overflow=0.
  - A following 0x01+0x01 must return 0x02.
- Back-to-back stream: 20 random operand pairs with random res_ready stalls. Every result, cout and overflow must match the reference model, in order, with no lost or duplicated transaction.

Source files
------------

// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package bsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MIN_WIDTH = 2;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_serial_adder_ctrl_fa_bit_cell.sv
// Single-bit full adder; the only arithmetic in the serial adder.
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell walked LSB first
// over WIDTH bits, with valid/ready handshakes on operands and result.
module bit_serial_adder_ctrl
    import bsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int                CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_start_ready;
    logic             r_res_valid;
    logic             w_s;
    logic             w_co;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == IDLE) && start_valid;
    assign w_last   = (r_cnt == LAST);

    fa_bit_cell u_cell (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_next_state = RUN;
            RUN:     if (w_last)      w_next_state = DONE;
            DONE:    if (res_ready)   w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_start_ready <= 1'b1;
            r_res_valid   <= 1'b0;
            r_res         <= '0;
            r_cout        <= 1'b0;
            r_ovf         <= 1'b0;
            r_cnt         <= '0;
            r_carry       <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_start_ready <= (w_next_state == IDLE);
            r_res_valid   <= (w_next_state == DONE);
            if (w_accept) begin
                // Subtract is A + ~B + 1, so the carry seeds with 1 and cin is ignored.
                r_carry <= sub | cin;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_res   <= {w_s, r_res[WIDTH-1:1]};
                r_carry <= w_co;
                if (w_last) begin
                    r_cout <= w_co;
                    r_ovf  <= r_carry ^ w_co;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= op_a;
            r_b <= sub ? ~op_b : op_b;
        end else if (r_state == RUN) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
        end
    end

    assign start_ready = r_start_ready;
    assign res_valid   = r_res_valid;
    assign result      = r_res;
    assign cout        = r_cout;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed and streamed checks of the bit-serial adder controller at WIDTH=8.
module tb_bit_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bit_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, check latency and outputs, stall in DONE, then release.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb, input int stall,
                          input logic [W-1:0] er, input logic ec, input logic eo,
                          input string tag);
        int lat;
        for (int i = 0; i < 40 && !start_ready; i++) step();
        chk({tag, "_rdy"}, 32'(start_ready), 32'd1);
        op_a = a; op_b = b; cin = ci; sub = sb; start_valid = 1'b1;
        step();
        start_valid = 1'b0; op_a = ~a; op_b = ~b; cin = ~ci; sub = ~sb;
        lat = 1;
        while (!res_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(W + 1));
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        chk({tag, "_busy"}, 32'(start_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            start_valid = i[0];
            op_a = W'($urandom); op_b = W'($urandom); sub = i[1];
            step();
            chk({tag, "_hold_v"}, 32'(res_valid), 32'd1);
            chk({tag, "_hold_r"}, {23'd0, overflow, cout, result}, {23'd0, eo, ec, er});
            chk({tag, "_hold_sr"}, 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_rel_v"}, 32'(res_valid), 32'd0);
        chk({tag, "_rel_sr"}, 32'(start_ready), 32'd1);
        chk({tag, "_rel_r"}, 32'(result), 32'(er));
    endtask

    initial begin
        logic [W-1:0] a, b, bb, er;
        logic [W:0]   s;
        logic         ci, sb, eo;

        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        step();
        step();
        chk("rst_sr", 32'(start_ready), 32'd1);
        chk("rst_v", 32'(res_valid), 32'd0);
        chk("rst_out", {23'd0, overflow, cout, result}, 32'd0);
        rst = 1'b0;
        step();

        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 0, 8'h8D, 1'b0, 1'b1, "add_5a_33");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run_op(8'h7F, 8'h00, 1'b1, 1'b0, 0, 8'h80, 1'b0, 1'b1, "add_7f_cin");
        run_op(8'h10, 8'h20, 1'b1, 1'b1, 0, 8'hF0, 1'b0, 1'b0, "sub_10_20");
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 5, 8'h7F, 1'b1, 1'b1, "sub_80_01_bp");

        // Abort after three RUN edges.
        op_a = 8'h5A; op_b = 8'h33; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_sr", 32'(start_ready), 32'd1);
        chk("abort_v", 32'(res_valid), 32'd0);
        chk("abort_out", {23'd0, overflow, cout, result}, 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 8'h02, 1'b0, 1'b0, "post_abort");

        for (int n = 0; n < 20; n++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom);
            sb = 1'($urandom);
            bb = sb ? ~b : b;
            s  = {1'b0, a} + {1'b0, bb} + {8'd0, (sb | ci)};
            er = s[W-1:0];
            eo = (a[W-1] == bb[W-1]) && (er[W-1] != a[W-1]);
            run_op(a, b, ci, sb, int'($urandom_range(0, 3)), er, s[W], eo, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
